// File: rtl/row_reduce_accumulator.sv
// row_reduce_accumulator: NI-lane adder tree feeding a row accumulator.
// Ports: clk, reset (sync, high); in_valid/in_last/in_data beat in;
//   out_valid/out_data/out_ovf/out_row_idx row result out; busy.
module row_reduce_accumulator #(
  parameter int NI    = 8,
  parameter int W     = 32,
  parameter int ACC_W = 48,
  parameter int SAT   = 1,
  parameter int RW    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [NI*W-1:0]   in_data,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic [RW-1:0]     out_row_idx,
  output logic              busy
);

  localparam int L = $clog2(NI);

  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic [L:0] vtag;

  // Stage 0 captures the beat; stage k>0 adds
  // adjacent pairs of stage k-1, one bit wider.
  genvar k, j;
  generate
    for (k = 0; k <= L; k++) begin : stg
      localparam int N  = NI >> k;
      localparam int SW = W + k;

      logic [SW-1:0] d [N];
      logic          v;
      logic          l;

      assign vtag[k] = v;

      if (k == 0) begin : g_in
        always_ff @(posedge clk) begin
          if (reset) begin
            v <= 1'b0;
            l <= 1'b0;
          end else begin
            v <= in_valid;
            l <= in_valid & in_last;
          end
        end
        for (j = 0; j < N; j++) begin : g_lane
          always_ff @(posedge clk) begin
            d[j] <= in_data[j*W +: W];
          end
        end
      end else begin : g_add
        always_ff @(posedge clk) begin
          if (reset) begin
            v <= 1'b0;
            l <= 1'b0;
          end else begin
            v <= stg[k-1].v;
            l <= stg[k-1].l;
          end
        end
        for (j = 0; j < N; j++) begin : g_pair
          always_ff @(posedge clk) begin
            d[j] <=
              {stg[k-1].d[2*j][SW-2],
               stg[k-1].d[2*j]} +
              {stg[k-1].d[2*j+1][SW-2],
               stg[k-1].d[2*j+1]};
          end
        end
      end
    end
  endgenerate

  logic             tv;
  logic             tl;
  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W:0]   acc_wide;
  logic             step_ovf;
  logic [ACC_W-1:0] nxt_acc;
  logic             nxt_ovf;

  logic [ACC_W-1:0] acc;
  logic             row_ovf;
  logic             first;

  assign tv = stg[L].v;
  assign tl = stg[L].l;

  always_comb begin
    sum_ext  = ACC_W'($signed(stg[L].d[0]));
    acc_wide = {acc[ACC_W-1], acc} +
               {sum_ext[ACC_W-1], sum_ext};
    // Out of range when the two top bits differ.
    step_ovf = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
    nxt_acc  = acc_wide[ACC_W-1:0];
    nxt_ovf  = row_ovf | step_ovf;
    if (step_ovf && SAT != 0) begin
      nxt_acc = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    if (first) begin
      nxt_acc = sum_ext;
      nxt_ovf = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      row_ovf     <= 1'b0;
      first       <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_row_idx <= '0;
    end else begin
      out_valid <= 1'b0;
      if (out_valid) begin
        out_row_idx <= out_row_idx + RW'(1);
      end
      if (tv) begin
        acc     <= nxt_acc;
        row_ovf <= nxt_ovf;
        if (tl) begin
          out_valid <= 1'b1;
          out_data  <= nxt_acc;
          out_ovf   <= nxt_ovf;
          first     <= 1'b1;
        end else begin
          first     <= 1'b0;
        end
      end
    end
  end

  assign busy = (|vtag) | ~first;

endmodule

// File: doc/row_reduce_accumulator.md
Name: row_reduce_accumulator

Overview:
- Parametrised successor to the fixed 8-lane row accumulator used in the matrix-vector datapath.
- Each beat carries NI signed lane values. A registered binary adder tree reduces them to one partial sum per beat.
- An accumulator sums the partial sums over all beats of a row and emits one row result per row.
- Row boundaries come from an explicit in_valid/in_last tag pipeline rather than a fixed delay chain. Adds saturation, overflow flagging, a row index and a busy indicator.

Parameters:
- NI, 8, lane count; power of two, >= 2.
- W, 32, lane width; signed two's complement.
- ACC_W, 48, accumulator and output width; must be >= W+log2(NI).
- SAT, 1, 1 = saturate the accumulator at signed ACC_W limits; 0 = wrap.
- RW, 16, row index width.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high reset.
- in_valid, input, 1, in_data holds a valid beat this cycle.
- in_last, input, 1, qualified by in_valid; marks the final beat of a row.
- in_data, input, NI*W, lane i occupies bits [i*W +: W].
- out_valid, output, 1, one-cycle pulse; the row result is on out_data.
- out_data, output, ACC_W, row sum; holds its value between pulses.
- out_ovf, output, 1, valid with out_valid; set if any accumulate step of that row overflowed ACC_W.
- out_row_idx, output, RW, index of the row on out_data; starts at 0.
- busy, output, 1, high while any valid beat is in the tree or a row is partially accumulated.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_ovf=0, out_row_idx=0, busy=0. All tree-stage valid/last tags cleared, accumulator cleared, first-beat flag set.
- Reset is checked before any other action. A reset mid-row discards the partial row and every beat in flight. No out_valid is produced for discarded data.
- Adder tree:
  - L = log2(NI) register stages; stage k adds adjacent pairs.
  - Width grows by 1 bit per stage, with sign extension; the final sum is W+L bits, so the tree never overflows.
  - valid and last travel alongside the data, one flop per stage.
  - Stage registers update every cycle; downstream logic ignores data whose valid tag is 0.
- Accumulator (one register stage after the tree):
  - The tree sum is sign-extended to ACC_W.
  - When the tag is valid and the first-beat flag is set: acc <= sum, and the row overflow flag is cleared.
  - When the tag is valid and the first-beat flag is clear: acc <= acc + sum, computed at ACC_W+1 bits.
  - Overflow occurs when the ACC_W+1-bit result lies outside the signed ACC_W range.
    - SAT=1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
    - SAT=0: truncate.
    - In both modes, set the sticky row overflow flag.
  - A valid beat with last=0 clears the first-beat flag.
  - A valid beat with last=1 does the following on the next edge:
    - out_data receives the final accumulated value, including the current beat.
    - out_ovf receives the row flag, including the current beat.
    - out_valid=1.
    - The first-beat flag is set again.
  - out_row_idx increments one cycle after each out_valid pulse. It wraps from 2^RW-1 to 0.
- Latency: a last beat sampled at edge n produces out_valid high during the cycle after edge n+L+1. With NI=8 that is 4 edges.
- Throughput: one beat per cycle, no backpressure. Rows may be back-to-back, and a single-beat row is legal (first and last together).
- Gaps: in_valid=0 cycles between beats of a row leave acc unchanged; gaps of any length are allowed.
- in_last is ignored when in_valid=0.
- busy = OR of all stage valid tags OR (first-beat flag clear).

Test Plan:
1. Assert reset for 2 cycles with random in_data and in_valid=1 -> out_valid stays 0, out_data=0, out_row_idx=0, busy=0. No pulse appears in the 6 cycles after reset drops with in_valid=0.
2. Single beat, lanes = 1,2,...,8, in_last=1 -> 4 edges later out_valid=1 for exactly one cycle, out_data=36, out_ovf=0, out_row_idx=0; busy then falls to 0.
3. Three-beat row, all lanes = 1, with 0, 2 and 5 idle cycles around the beats, last on beat 3 -> a single out_valid with out_data=24.
4. Back-to-back single-beat rows on consecutive cycles: all lanes = 2, then all lanes = -1 -> out_valid high on two consecutive cycles with out_data 16 then 0xFFFF_FFFF_FFF8 (-8), out_row_idx 0 then 1; out_row_idx reads 2 afterwards.
5. Overflow, parameters ACC_W=36 and SAT=1: 3-beat row, all lanes = 0x7FFF_FFFF -> out_data=0x7_FFFF_FFFF, out_ovf=1. The next row, a single beat of all lanes = 1, gives out_data=8 and out_ovf=0. With SAT=0 the same overflow row gives out_ovf=1 and wrapped data.
6. Reset mid-row: two beats of all lanes = 5 with last=0, pulse reset, then a single beat of all lanes = 1 with last=1 -> out_data=8; no output ever includes the earlier 80.
